// File: rtl/cache_page_tagger.sv
// cache_page_tagger: page-tag front end for a 65816-style bus.
// Tracks PAGES resident 256-byte pages by {bank, a[15:8]} with true-LRU
// replacement and issues fill requests to the page loader on a miss.
// Optional feature macro: CACHE_STATS_EN (saturating hit/miss counters).
module cache_page_tagger #(
   parameter  int PAGES = 4,
   parameter  int TAG_W = 16,
   localparam int IDX_W = $clog2(PAGES)
) (
   input  logic             fpga,
   input  logic             rst_n,
   input  logic             phi2,
   input  logic [15:0]      a,
   input  logic [7:0]       d,
   output logic             hit,
   output logic             miss,
   output logic [IDX_W-1:0] page_idx,
   output logic [7:0]       offset,
   output logic             fill_req,
   output logic [TAG_W-1:0] fill_tag,
   output logic [IDX_W-1:0] fill_page,
   input  logic             fill_ack,
   output logic             busy,
   output logic             overrun,
   output logic [15:0]      hit_count,
   output logic [15:0]      miss_count
);

   typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

   state_t           r_state, w_state_next;
   logic             r_phi2_s1, r_phi2_s2, r_phi2_s3;
   logic [7:0]       r_bank_q;
   logic [23:0]      r_req;
   logic             r_req_v;
   logic [TAG_W-1:0] r_tag [PAGES];
   logic [PAGES-1:0] r_valid;
   logic [IDX_W-1:0] r_age [PAGES];

   logic             r_hit, r_miss, r_fill_req, r_busy, r_overrun;
   logic [IDX_W-1:0] r_page_idx, r_fill_page;
   logic [7:0]       r_offset;
   logic [TAG_W-1:0] r_fill_tag;

   logic             w_rise, w_lookup, w_fill_done, w_hit_any, w_any_inv;
   logic [TAG_W-1:0] w_req_tag;
   logic [PAGES-1:0] w_match;
   logic [IDX_W-1:0] w_hit_idx, w_inv_idx, w_lru_idx, w_victim;
   logic             w_upd_en;
   logic [IDX_W-1:0] w_upd_idx, w_upd_age;

   assign w_rise      = r_phi2_s2 & ~r_phi2_s3;
   assign w_req_tag   = r_req[23:8];
   assign w_lookup    = (r_state == S_IDLE) && r_req_v;
   assign w_fill_done = (r_state == S_FILL) && fill_ack;

   // Bank byte is only meaningful while phi2 is low; hold it otherwise.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n)    r_bank_q <= '0;
      else if (!phi2) r_bank_q <= d;
   end

   // Two-flop synchroniser plus edge flop for the asynchronous phi2.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         r_phi2_s1 <= 1'b0;
         r_phi2_s2 <= 1'b0;
         r_phi2_s3 <= 1'b0;
      end else begin
         r_phi2_s1 <= phi2;
         r_phi2_s2 <= r_phi2_s1;
         r_phi2_s3 <= r_phi2_s2;
      end
   end

   // Parallel tag compare, one comparator per page.
   for (genvar gi = 0; gi < PAGES; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] && (r_tag[gi] == w_req_tag);
   end

   // Encode the matching page and choose the replacement victim.
   always_comb begin
      w_hit_any = |w_match;
      w_any_inv = ~&r_valid;
      w_hit_idx = '0;
      w_lru_idx = '0;
      w_inv_idx = '0;
      for (int i = 0; i < PAGES; i++) begin
         if (w_match[i]) w_hit_idx = IDX_W'(i);
         if (r_age[i] == IDX_W'(PAGES - 1)) w_lru_idx = IDX_W'(i);
      end
      for (int i = PAGES - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_inv_idx = IDX_W'(i);
      end
      w_victim = w_any_inv ? w_inv_idx : w_lru_idx;
   end

   // A hit lookup and a fill completion never coincide (IDLE vs FILL).
   always_comb begin
      w_upd_en  = 1'b0;
      w_upd_idx = '0;
      if (w_lookup && w_hit_any) begin
         w_upd_en  = 1'b1;
         w_upd_idx = w_hit_idx;
      end else if (w_fill_done) begin
         w_upd_en  = 1'b1;
         w_upd_idx = r_fill_page;
      end
      w_upd_age = r_age[w_upd_idx];
   end

   // FSM state register.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next state: a missing lookup enters FILL, the loader ack leaves it.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_lookup && !w_hit_any) w_state_next = S_FILL;
         S_FILL: if (fill_ack)               w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Request slot: doubles as the 1-deep pending slot while a fill runs.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         r_req     <= '0;
         r_req_v   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_rise) begin
         if (!r_req_v || w_lookup) begin
            r_req   <= {r_bank_q, a};
            r_req_v <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (w_lookup) begin
         r_req_v <= 1'b0;
      end
   end

   // Tag and valid storage, written when the loader completes a fill.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < PAGES; i++) r_tag[i] <= '0;
      end else if (w_fill_done) begin
         r_tag[r_fill_page]   <= r_fill_tag;
         r_valid[r_fill_page] <= 1'b1;
      end
   end

   // True-LRU ages: accessed page goes to 0, younger pages age by one.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PAGES; i++) r_age[i] <= IDX_W'(i);
      end else if (w_upd_en) begin
         for (int i = 0; i < PAGES; i++) begin
            if (IDX_W'(i) == w_upd_idx)     r_age[i] <= '0;
            else if (r_age[i] < w_upd_age) r_age[i] <= r_age[i] + 1'b1;
         end
      end
   end

   // Registered result pulses and fill handshake outputs.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
         r_page_idx  <= '0;
         r_offset    <= '0;
         r_fill_req  <= 1'b0;
         r_fill_tag  <= '0;
         r_fill_page <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         if (w_lookup) begin
            r_offset <= r_req[7:0];
            if (w_hit_any) begin
               r_hit      <= 1'b1;
               r_page_idx <= w_hit_idx;
            end else begin
               r_miss      <= 1'b1;
               r_fill_req  <= 1'b1;
               r_busy      <= 1'b1;
               r_fill_tag  <= w_req_tag;
               r_fill_page <= w_victim;
               r_page_idx  <= w_victim;
            end
         end
         if (w_fill_done) begin
            r_fill_req <= 1'b0;
            r_busy     <= 1'b0;
            r_page_idx <= r_fill_page;
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] r_hit_cnt, r_miss_cnt;

   // Saturating access statistics.
   always_ff @(posedge fpga or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_lookup) begin
         if (w_hit_any && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
         if (!w_hit_any && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`else
   assign hit_count  = 16'h0000;
   assign miss_count = 16'h0000;
`endif

   assign hit       = r_hit;
   assign miss      = r_miss;
   assign page_idx  = r_page_idx;
   assign offset    = r_offset;
   assign fill_req  = r_fill_req;
   assign fill_tag  = r_fill_tag;
   assign fill_page = r_fill_page;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule
